// File: rtl/range_seq_ctrl.sv
// range_seq_ctrl: session sequencer feeding samples to a range datapath and holding its result.
// Optional idle-RUN timeout of TIMEOUT cycles is enabled by defining RANGE_SEQ_TIMEOUT_EN.
module range_seq_ctrl #(
    parameter int WIDTH   = 10,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_data,
    output logic             sample_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             busy,
    output logic             err
);
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, HOLD} state_t;

    state_t           state, next;
    logic [CNT_W-1:0] len_q, count, count_inc;
    logic             accept, last, tmo;

    assign count_inc = count + 1'b1;
    assign accept    = sample_valid && sample_ready;
    assign last      = accept && count_inc == len_q;

`ifdef RANGE_SEQ_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    // fires on the TIMEOUT-th consecutive RUN cycle without an accept
    assign tmo = state == RUN && !accept && idle_cnt == IW'(TIMEOUT - 1);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) idle_cnt <= '0;
        else          idle_cnt <= (state == RUN && !accept) ? idle_cnt + 1'b1 : '0;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (start && frame_len != '0) ? RUN : IDLE;
            RUN:     next = last ? DRAIN : tmo ? ((count != '0) ? DRAIN : IDLE) : RUN;
            DRAIN:   next = FINISH;
            FINISH:  next = HOLD;
            HOLD:    next = result_ack ? IDLE : HOLD;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        sample_ready = state == RUN;
        busy         = state != IDLE;
        result_valid = state == HOLD;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q     <= '0;
            count     <= '0;
            rf_data   <= '0;
            rf_go     <= 1'b0;
            rf_finish <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
        end else begin
            rf_go     <= accept;
            rf_finish <= next == FINISH;
            if (accept) begin
                rf_data <= sample_data;
                count   <= count_inc;
            end
            if (state == IDLE && start) begin
                len_q <= frame_len;
                count <= '0;
            end
            if (state == FINISH) result <= rf_range;
            if (state == IDLE && start) err <= frame_len == '0;
            else if ((state != IDLE && rf_error) || tmo) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_range_seq_ctrl.sv
// tb_range_seq_ctrl: directed bench for range_seq_ctrl with a behavioural min/max datapath.
// Define RANGE_SEQ_TIMEOUT_EN to also exercise the timeout scenarios (TIMEOUT=8).
module tb_range_seq_ctrl;
    logic       clock, reset_n, start, sample_valid, sample_ready, rf_go, rf_finish;
    logic       rf_error, result_valid, result_ack, busy, err;
    logic [7:0] frame_len;
    logic [9:0] sample_data, rf_data, rf_range, result;
    logic [9:0] dmin, dmax;
    logic       dempty;
    int         n_chk, n_fail, go_cnt, fin_cnt, overlap;

    range_seq_ctrl #(.WIDTH(10), .CNT_W(8), .TIMEOUT(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .frame_len(frame_len),
        .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish), .rf_range(rf_range),
        .rf_error(rf_error), .result(result), .result_valid(result_valid),
        .result_ack(result_ack), .busy(busy), .err(err)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // external datapath: tracks min/max of rf_go samples, clears on rf_finish
    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            dempty <= 1; dmin <= 0; dmax <= 0;
        end else if (rf_finish) dempty <= 1;
        else if (rf_go) begin
            if (dempty) begin dmin <= rf_data; dmax <= rf_data; dempty <= 0; end
            else begin
                if (rf_data < dmin) dmin <= rf_data;
                if (rf_data > dmax) dmax <= rf_data;
            end
        end
    assign rf_range = dempty ? 10'd0 : dmax - dmin;

    always @(posedge clock) begin
        if (rf_go) go_cnt++;
        if (rf_finish) fin_cnt++;
        if (rf_go && rf_finish) overlap++;
    end

    task automatic tick;
        @(posedge clock); #1;
    endtask

    task automatic begin_session(input logic [7:0] len);
        start = 1; frame_len = len; tick; start = 0;
    endtask

    task automatic test_reset;
        reset_n = 0; start = 0; frame_len = 0; sample_valid = 0; sample_data = 0;
        rf_error = 0; result_ack = 0;
        tick; tick;
        n_chk++; if ({rf_go, rf_finish, sample_ready, result_valid, busy, err} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000000", {rf_go, rf_finish, sample_ready, result_valid, busy, err}); end
        n_chk++; if (result !== 0 || rf_data !== 0) begin
            n_fail++; $display("FAIL reset_data: got result=%0d rf_data=%0d want 0 0", result, rf_data); end
        #3 reset_n = 1; tick;
        n_chk++; if (busy !== 0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [9:0] s [4];
        s[0] = 7; s[1] = 3; s[2] = 12; s[3] = 5;
        go_cnt = 0; fin_cnt = 0;
        begin_session(4);
        n_chk++; if (busy !== 1 || sample_ready !== 1) begin
            n_fail++; $display("FAIL b2b_run: busy=%b ready=%b want 1 1", busy, sample_ready); end
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1; sample_data = s[i]; tick;
            n_chk++; if (rf_go !== 1 || rf_data !== s[i]) begin
                n_fail++; $display("FAIL b2b_go[%0d]: go=%b data=%0d want 1 %0d", i, rf_go, rf_data, s[i]); end
        end
        sample_valid = 0;
        n_chk++; if (sample_ready !== 0 || busy !== 1) begin
            n_fail++; $display("FAIL b2b_drain: ready=%b busy=%b want 0 1", sample_ready, busy); end
        tick;
        n_chk++; if (rf_finish !== 1 || rf_go !== 0) begin
            n_fail++; $display("FAIL b2b_finish: finish=%b go=%b want 1 0", rf_finish, rf_go); end
        tick;
        n_chk++; if (result_valid !== 1 || result !== 9 || rf_finish !== 0) begin
            n_fail++; $display("FAIL b2b_result: valid=%b result=%0d finish=%b want 1 9 0", result_valid, result, rf_finish); end
        tick; tick;
        n_chk++; if (result_valid !== 1 || result !== 9) begin
            n_fail++; $display("FAIL b2b_hold: valid=%b result=%0d want 1 9", result_valid, result); end
        result_ack = 1; tick; result_ack = 0;
        n_chk++; if (result_valid !== 0 || busy !== 0) begin
            n_fail++; $display("FAIL b2b_ack: valid=%b busy=%b want 0 0", result_valid, busy); end
        n_chk++; if (go_cnt !== 4 || fin_cnt !== 1 || err !== 0) begin
            n_fail++; $display("FAIL b2b_counts: go=%0d fin=%0d err=%b want 4 1 0", go_cnt, fin_cnt, err); end
    endtask

    task automatic test_gaps;
        logic       v [6];
        logic [9:0] d [6];
        v[0] = 1; v[1] = 0; v[2] = 0; v[3] = 1; v[4] = 0; v[5] = 1;
        d[0] = 20; d[1] = 0; d[2] = 0; d[3] = 8; d[4] = 0; d[5] = 15;
        begin_session(3);
        for (int i = 0; i < 6; i++) begin
            sample_valid = v[i]; sample_data = d[i]; tick;
            n_chk++; if (rf_go !== v[i]) begin
                n_fail++; $display("FAIL gap_go[%0d]: go=%b want %b", i, rf_go, v[i]); end
        end
        sample_valid = 0;
        n_chk++; if (sample_ready !== 0) begin n_fail++; $display("FAIL gap_drain: ready=%b want 0", sample_ready); end
        tick; tick;
        n_chk++; if (result_valid !== 1 || result !== 12) begin
            n_fail++; $display("FAIL gap_result: valid=%b result=%0d want 1 12", result_valid, result); end
        result_ack = 1; tick; result_ack = 0;
    endtask

    task automatic test_zero_len;
        go_cnt = 0;
        begin_session(0);
        n_chk++; if (busy !== 0 || err !== 1) begin
            n_fail++; $display("FAIL zero_idle: busy=%b err=%b want 0 1", busy, err); end
        sample_valid = 1; sample_data = 33; tick; tick; sample_valid = 0;
        n_chk++; if (go_cnt !== 0 || sample_ready !== 0) begin
            n_fail++; $display("FAIL zero_nogo: go=%0d ready=%b want 0 0", go_cnt, sample_ready); end
        begin_session(1);
        n_chk++; if (err !== 0 || busy !== 1) begin
            n_fail++; $display("FAIL zero_restart: err=%b busy=%b want 0 1", err, busy); end
        sample_valid = 1; sample_data = 6; tick; sample_valid = 0; tick; tick;
        n_chk++; if (result_valid !== 1 || result !== 0) begin
            n_fail++; $display("FAIL zero_result: valid=%b result=%0d want 1 0", result_valid, result); end
        result_ack = 1; tick; result_ack = 0;
    endtask

    task automatic test_error_hold;
        begin_session(2);
        sample_valid = 1; sample_data = 50; rf_error = 1; tick; rf_error = 0;
        n_chk++; if (err !== 1) begin n_fail++; $display("FAIL errh_set: err=%b want 1", err); end
        sample_data = 30; tick; sample_valid = 0; tick;
        n_chk++; if (rf_finish !== 1) begin n_fail++; $display("FAIL errh_finish: finish=%b want 1", rf_finish); end
        tick;
        n_chk++; if (result !== 20 || err !== 1 || result_valid !== 1) begin
            n_fail++; $display("FAIL errh_result: result=%0d err=%b valid=%b want 20 1 1", result, err, result_valid); end
        start = 1; frame_len = 3;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++; if (result_valid !== 1 || busy !== 1 || result !== 20) begin
                n_fail++; $display("FAIL errh_ignore[%0d]: valid=%b busy=%b result=%0d want 1 1 20", i, result_valid, busy, result); end
        end
        start = 0; result_ack = 1; tick; result_ack = 0;
        n_chk++; if (busy !== 0 || result_valid !== 0 || err !== 1) begin
            n_fail++; $display("FAIL errh_ack: busy=%b valid=%b err=%b want 0 0 1", busy, result_valid, err); end
    endtask

    task automatic test_reset_mid;
        fin_cnt = 0;
        begin_session(5);
        sample_valid = 1; sample_data = 99; rf_error = 1; tick; rf_error = 0;
        sample_data = 40; tick;
        #2 reset_n = 0; #1;
        n_chk++; if ({rf_go, rf_finish, sample_ready, result_valid, busy, err} !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_flags: got %b want 000000", {rf_go, rf_finish, sample_ready, result_valid, busy, err}); end
        n_chk++; if (rf_data !== 0 || result !== 0) begin
            n_fail++; $display("FAIL rstmid_data: rf_data=%0d result=%0d want 0 0", rf_data, result); end
        #2 reset_n = 1; sample_valid = 0; tick;
        n_chk++; if (busy !== 0 || sample_ready !== 0) begin
            n_fail++; $display("FAIL rstmid_idle: busy=%b ready=%b want 0 0", busy, sample_ready); end
        tick; tick; tick;
        n_chk++; if (fin_cnt !== 0) begin n_fail++; $display("FAIL rstmid_nofinish: finishes=%0d want 0", fin_cnt); end
    endtask

    task automatic test_max_len;
        go_cnt = 0;
        begin_session(8'd255);
        for (int i = 0; i < 255; i++) begin
            sample_valid = 1; sample_data = 10'(i); tick;
        end
        sample_valid = 0;
        n_chk++; if (sample_ready !== 0 || busy !== 1) begin
            n_fail++; $display("FAIL max_drain: ready=%b busy=%b want 0 1", sample_ready, busy); end
        tick; tick;
        n_chk++; if (result_valid !== 1 || result !== 254 || go_cnt !== 255) begin
            n_fail++; $display("FAIL max_result: valid=%b result=%0d go=%0d want 1 254 255", result_valid, result, go_cnt); end
        result_ack = 1; tick; result_ack = 0;
    endtask

`ifdef RANGE_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        fin_cnt = 0;
        begin_session(5);
        sample_valid = 1; sample_data = 11; tick; sample_data = 4; tick; sample_valid = 0;
        for (int i = 0; i < 7; i++) tick;
        n_chk++; if (sample_ready !== 1 || err !== 0) begin
            n_fail++; $display("FAIL tmo_before: ready=%b err=%b want 1 0", sample_ready, err); end
        tick;
        n_chk++; if (sample_ready !== 0 || busy !== 1 || err !== 1) begin
            n_fail++; $display("FAIL tmo_drain: ready=%b busy=%b err=%b want 0 1 1", sample_ready, busy, err); end
        tick;
        n_chk++; if (rf_finish !== 1) begin n_fail++; $display("FAIL tmo_finish: finish=%b want 1", rf_finish); end
        tick;
        n_chk++; if (result_valid !== 1 || result !== 7 || err !== 1) begin
            n_fail++; $display("FAIL tmo_result: valid=%b result=%0d err=%b want 1 7 1", result_valid, result, err); end
        result_ack = 1; tick; result_ack = 0;
        fin_cnt = 0;
        begin_session(3);
        n_chk++; if (err !== 0) begin n_fail++; $display("FAIL tmo0_clear: err=%b want 0", err); end
        for (int i = 0; i < 7; i++) tick;
        n_chk++; if (busy !== 1) begin n_fail++; $display("FAIL tmo0_before: busy=%b want 1", busy); end
        tick;
        n_chk++; if (busy !== 0 || err !== 1) begin
            n_fail++; $display("FAIL tmo0_idle: busy=%b err=%b want 0 1", busy, err); end
        tick; tick;
        n_chk++; if (result_valid !== 0 || fin_cnt !== 0) begin
            n_fail++; $display("FAIL tmo0_noresult: valid=%b finishes=%0d want 0 0", result_valid, fin_cnt); end
    endtask
`endif

    initial begin
        n_chk = 0; n_fail = 0; go_cnt = 0; fin_cnt = 0; overlap = 0;
        test_reset;
        test_back_to_back;
        test_gaps;
        test_zero_len;
        test_error_hold;
        test_reset_mid;
        test_max_len;
`ifdef RANGE_SEQ_TIMEOUT_EN
        test_timeout;
`endif
        n_chk++; if (overlap !== 0) begin n_fail++; $display("FAIL go_finish_overlap: cycles=%0d want 0", overlap); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
